// File: rtl/register_file_32x32_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
package register_file_32x32_pkg;

    // Datapath word width and register index width.
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Number of architectural registers addressed by ADDR_W.
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    // Named MIPS register indices.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    // True when a write-port request actually targets architectural storage.
    function automatic logic write_is_live(
        input logic     reg_write,
        input logic     reset,
        input reg_idx_t write_reg
    );
        return reg_write && !reset && (write_reg != REG_ZERO);
    endfunction

endpackage : register_file_32x32_pkg

// File: rtl/register_file_32x32_register_word.sv
// One storage word of the register file: synchronous reset, load enable.
module register_word #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state: take the new word when loaded, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    // State register with synchronous active-high clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : register_word

// File: rtl/register_file_32x32.sv
// 32 x 32-bit MIPS register file: one synchronous write port, two
// combinational read ports, $0 hardwired to zero, write-to-read forwarding.
module register_file_32x32 #(
    parameter int unsigned DATA_W = register_file_32x32_pkg::DATA_W,
    parameter int unsigned ADDR_W = register_file_32x32_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import register_file_32x32_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Write strobes and stored words exist only for indices 1..DEPTH-1;
    // register 0 has no storage at all.
    logic [DEPTH-1:1]  wr_en;
    logic [DATA_W-1:0] word_q [1:DEPTH-1];

    logic              wr_live;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              fwd1;
    logic              fwd2;

    assign wr_live = write_is_live(reg_write, reset, write_reg);

    // Write decoder: one-hot strobe for the addressed non-zero register.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            wr_en[i] = wr_live && (write_reg == ADDR_W'(i));
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_word
        register_word #(
            .DATA_W(DATA_W)
        ) u_word (
            .clk    (clk),
            .reset  (reset),
            .load_i (wr_en[g]),
            .d_i    (write_data),
            .q_o    (word_q[g])
        );
    end

    // Read port 1 storage mux; index 0 falls through to zero.
    always_comb begin
        stored1 = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (read_reg1 == ADDR_W'(i)) begin
                stored1 = word_q[i];
            end
        end
    end

    // Read port 2 storage mux; index 0 falls through to zero.
    always_comb begin
        stored2 = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (read_reg2 == ADDR_W'(i)) begin
                stored2 = word_q[i];
            end
        end
    end

    // Forwarding compare: wr_live already excludes reset and index 0, so a
    // read of $0 or a read during reset never sees the write-port word.
    always_comb begin
        fwd1 = wr_live && (read_reg1 == write_reg);
        fwd2 = wr_live && (read_reg2 == write_reg);
    end

    // Output override mux: same-cycle write data beats stored contents.
    always_comb begin
        read_data1 = fwd1 ? write_data : stored1;
        read_data2 = fwd2 ? write_data : stored2;
    end

endmodule : register_file_32x32

// File: tb/tb_register_file_32x32.sv
// Directed self-checking bench for register_file_32x32.
module tb_register_file_32x32;

    import register_file_32x32_pkg::*;

    logic              clk;
    logic              reset;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    int unsigned n_checks;
    int unsigned n_fail;

    register_file_32x32 #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic drive(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r1,
                         input logic [ADDR_W-1:0] r2);
        @(negedge clk);
        reset      = rst;
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // Reset state: first edge at t=5 with reset high.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, REG_RA);
        check_eq("rst_r5", read_data1, 32'h0);
        check_eq("rst_r31", read_data2, 32'h0);

        // Reset clear.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check_eq("pre_rst_r5", read_data1, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check_eq("clr_r5_p1", read_data1, 32'h0);
        check_eq("clr_r5_p2", read_data2, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, REG_RA, REG_RA);
        check_eq("clr_r31_p1", read_data1, 32'h0);
        check_eq("clr_r31_p2", read_data2, 32'h0);

        // Zero register: write to $0 is discarded and never forwarded.
        drive(1'b0, 1'b1, REG_ZERO, 32'hFFFFFFFF, REG_ZERO, REG_ZERO);
        check_eq("zero_now_p1", read_data1, 32'h0);
        check_eq("zero_now_p2", read_data2, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, REG_ZERO, REG_ZERO);
        check_eq("zero_next_p1", read_data1, 32'h0);
        check_eq("zero_next_p2", read_data2, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
        check_eq("zero_r5_hold", read_data1, 32'h0);
        check_eq("zero_r1_hold", read_data2, 32'h0);

        // Write all, then read pairs (i, 32-i).
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'd0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
            check_eq($sformatf("all_p1_r%0d", i), read_data1, 32'h1000_0000 + 32'(i));
            check_eq($sformatf("all_p2_r%0d", 32 - i), read_data2, 32'h1000_0000 + 32'(32 - i));
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, REG_ZERO, REG_SP);
        check_eq("all_r0", read_data1, 32'h0);
        check_eq("all_sp", read_data2, 32'h1000_001D);

        // Forwarding on both ports, then from storage.
        drive(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
        check_eq("fwd_p1", read_data1, 32'h22222222);
        check_eq("fwd_p2", read_data2, 32'h22222222);
        drive(1'b0, 1'b0, 5'd7, 32'h33333333, 5'd7, 5'd7);
        check_eq("fwd_store_p1", read_data1, 32'h22222222);
        check_eq("fwd_store_p2", read_data2, 32'h22222222);

        // Back-to-back writes to r8: each forwarded, last one stored.
        drive(1'b0, 1'b1, 5'd8, 32'hAAAA0001, 5'd8, 5'd9);
        check_eq("b2b_fwd_a", read_data1, 32'hAAAA0001);
        check_eq("b2b_other", read_data2, 32'h1000_0009);
        drive(1'b0, 1'b1, 5'd8, 32'hBBBB0002, 5'd9, 5'd8);
        check_eq("b2b_fwd_b", read_data2, 32'hBBBB0002);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        check_eq("b2b_store", read_data1, 32'hBBBB0002);

        // Write disabled: no forwarding, no store.
        drive(1'b0, 1'b1, 5'd9, 32'h5, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd9, 32'hABCD0123, 5'd9, 5'd0);
        check_eq("wdis_now", read_data1, 32'h5);
        drive(1'b0, 1'b0, 5'd9, 32'hABCD0123, 5'd9, 5'd0);
        check_eq("wdis_next", read_data1, 32'h5);

        // Reset collision: no forwarding under reset, write dropped.
        drive(1'b1, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
        check_eq("coll_pre_p1", read_data1, 32'h1000_0003);
        check_eq("coll_pre_p2", read_data2, 32'h1000_0003);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
        check_eq("coll_post", read_data1, 32'h0);
        check_eq("coll_r9_clr", read_data2, 32'h0);
        // First cycle after reset deasserts: write performed normally.
        drive(1'b0, 1'b1, 5'd4, 32'hCAFEF00D, 5'd3, 5'd4);
        check_eq("coll_r3_zero", read_data1, 32'h0);
        check_eq("post_rst_fwd", read_data2, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
        check_eq("post_rst_store", read_data1, 32'hCAFEF00D);
        check_eq("coll_r3_final", read_data2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_32x32

// File: doc/register_file_32x32.md
# register_file_32x32

Write-back destination of the datapath: a 32-entry × 32-bit MIPS general-purpose register file. It consumes the 32-bit word selected by the write-back 2:1 mux (ALU result vs. memory data) and supplies two operand words per cycle to the ALU input muxes. It has one synchronous write port and two combinational read ports. Register $0 is hardwired to zero, and a same-cycle write is forwarded to the read ports.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W = 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers on the rising edge while high.
- reg_write  input  1  write enable from control.
- write_reg  input  ADDR_W  destination register index (rd or rt, already selected upstream).
- write_data  input  DATA_W  write-back word from the write-back mux.
- read_reg1  input  ADDR_W  source index rs.
- read_reg2  input  ADDR_W  source index rt.
- read_data1  output  DATA_W  operand word for rs.
- read_data2  output  DATA_W  operand word for rt.

One clock. Reset is synchronous and active-high.

## Operation
- Storage: registers 1..31 are DATA_W-bit flops. Register 0 has no storage and always reads 0.
- Write: on a rising clk edge with reset=0, reg_write=1 and write_reg≠0, the register at write_reg takes write_data. All other registers hold.
- Writes to index 0 are discarded silently.
- Reset: on a rising clk edge with reset=1, registers 1..31 become 0. Reset has priority over any write in the same cycle; that write is lost.
- Read ports are combinational and independent. Both may address the same register.
- Read of index 0 returns 0.
- Forwarding: if reset=0, reg_write=1, write_reg≠0 and read_regN==write_reg, then read_dataN=write_data in the same cycle. Otherwise read_dataN is the stored value.
- Forwarding applies to both ports at once when both match.
- Forwarding is suppressed while reset=1. Reads then return stored contents, which are all 0 after the first reset edge.
- X or undefined indices are not permitted. The verification environment asserts that all indices are known whenever reg_write=1.

## Timing
- Write latency: data presented in cycle N is stored at the rising edge ending cycle N. It is visible from storage in cycle N+1, and in cycle N through forwarding.
- Read latency: 0 cycles; purely combinational from read_reg*/write-port signals to read_data*.
- Output values after reset: once one rising edge has occurred with reset=1, read_data1 = read_data2 = 0 for every index until a write occurs. Before the first reset edge, contents are undefined except register 0.
- Reset mid-operation: a write coincident with the reset edge is dropped. A write in the first cycle after reset deasserts is performed normally.
- Back-to-back writes to the same register on consecutive cycles: the last one wins, and each is forwarded in its own cycle.
- Critical path: write_data → forwarding compare/mux → read_data. The 32:1 read mux must settle within one cycle together with the downstream ALU-input mux.

## Structure
- Shared package holds:
  - DATA_W = 32 and ADDR_W = 5.
  - REG_ZERO = 5'd0, plus the named MIPS indices used by benches: REG_SP = 29, REG_RA = 31.
- Sub-module register_word: a DATA_W-bit flop with synchronous active-high reset and load enable. It is instantiated 31 times (indices 1..31).
- The top level contains:
  - the 5→32 write decoder, with enable gated by reg_write, write_reg≠0 and !reset;
  - two 32:1 read muxes;
  - the per-port forwarding compare and override mux.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, assert reset for one edge, then read r5 and r31 on both ports → 0x00000000 on both.
- Zero register: write 0xFFFFFFFF to r0 with reg_write=1, then read r0 on both ports the same cycle and the next → 0x00000000. No other register changes.
- Write/read all: write r(i)=0x1000_0000+i for i=1..31, then read pairs (i, 32−i) → both values are exact. Read r0 → 0.
- Forwarding: r7 holds 0x11111111. In one cycle, write r7=0x22222222 while read_reg1=read_reg2=7 → both ports show 0x22222222 combinationally. The next cycle with reg_write=0 shows 0x22222222 from storage.
- Write disabled: reg_write=0, write_reg=9, write_data=0xABCD0123, read_reg1=9, with r9=0x5 → read_data1=0x5 in the same cycle and the next.
- Reset collision: reset=1 with reg_write=1, write_reg=3, write_data=0x12345678, read_reg1=3 → read_data1 is the pre-edge stored value (no forwarding), then 0 after the edge. r3 stays 0 after reset deasserts.
